// File: rtl/adc_pingpong_buf.sv
// Ping/pong sample buffer: fills one bank from the selected ADC channel while the other is read out.
// Define ADC_TEST_PATTERN_EN to write a per-channel ramp instead of adc_data.
module adc_pingpong_buf #(
   parameter int unsigned DATA_NBIT = 16,
   parameter int unsigned ADDR_NBIT = 10,
   parameter int unsigned CNT_NBIT  = 32,
   parameter int unsigned CHN_NBIT  = 3
) (
   input  logic                 mclk,
   input  logic                 rst_n,
   input  logic                 ad_acq_en,
   input  logic [CHN_NBIT-1:0]  ad_chn,
   input  logic                 adc_vd,
   input  logic [DATA_NBIT-1:0] adc_data,
   output logic [CHN_NBIT-1:0]  adc_chn_sel,
   output logic                 ad_switch,
   input  logic                 ad_rd,
   output logic [DATA_NBIT-1:0] ad_data,
   output logic [CNT_NBIT-1:0]  ad_cnt,
   output logic                 ad_ovf
);

   localparam int unsigned DEPTH     = 1 << ADDR_NBIT;
   localparam int unsigned RAM_WORDS = 2 * DEPTH;
   localparam logic [ADDR_NBIT-1:0] PTR_MAX = '1;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_FILL = 2'd1;
   localparam logic [1:0] ST_SWAP = 2'd2;

   logic [1:0]           state_q, state_d;
   logic                 acq_en_q;
   logic                 wr_bank, rd_bank;
   logic [ADDR_NBIT-1:0] wr_ptr, rd_ptr;
   logic [ADDR_NBIT:0]   rd_cnt, rd_cnt_nxt;
   logic                 rd_valid;
   logic [CNT_NBIT-1:0]  frame_cnt;
   logic [DATA_NBIT-1:0] mem [RAM_WORDS];
   logic [DATA_NBIT-1:0] ram_q;
   logic [DATA_NBIT-1:0] wr_word;

   logic wr_last, chn_change;
   logic do_start, do_write, do_restart, do_swap;

   assign wr_last    = adc_vd && (wr_ptr == PTR_MAX);
   assign chn_change = (ad_chn != adc_chn_sel);

   // read pulses on the readable bank since its swap, saturating at one full bank
   assign rd_cnt_nxt = (ad_rd && !rd_cnt[ADDR_NBIT]) ? rd_cnt + (ADDR_NBIT+1)'(1) : rd_cnt;

`ifdef ADC_TEST_PATTERN_EN
   logic unused_adc_data;
   assign unused_adc_data = ^adc_data;
   assign wr_word = DATA_NBIT'({8'(adc_chn_sel), 8'(wr_ptr)});
`else
   assign wr_word = adc_data;
`endif

   always_ff @(posedge mclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // the completing write outranks a falling enable; otherwise enable low aborts the bank
   always_comb begin
      state_d    = state_q;
      do_start   = 1'b0;
      do_write   = 1'b0;
      do_restart = 1'b0;
      do_swap    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (ad_acq_en && !acq_en_q) begin
               state_d  = ST_FILL;
               do_start = 1'b1;
            end
         end
         ST_FILL: begin
            if (!ad_acq_en && !wr_last) begin
               state_d = ST_IDLE;
            end else if (ad_acq_en && chn_change) begin
               do_restart = 1'b1;
            end else if (adc_vd) begin
               do_write = 1'b1;
               if (wr_last) begin
                  state_d = ST_SWAP;
               end
            end
         end
         ST_SWAP: begin
            do_swap = 1'b1;
            state_d = ad_acq_en ? ST_FILL : ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge mclk or negedge rst_n) begin
      if (!rst_n) begin
         acq_en_q    <= 1'b0;
         adc_chn_sel <= '0;
         ad_switch   <= 1'b0;
         ad_cnt      <= '0;
         ad_ovf      <= 1'b0;
         wr_bank     <= 1'b0;
         rd_bank     <= 1'b0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         rd_cnt      <= '0;
         rd_valid    <= 1'b0;
         frame_cnt   <= '0;
      end else begin
         acq_en_q <= ad_acq_en;

         if (do_start || do_restart) begin
            adc_chn_sel <= ad_chn;
         end

         if (do_write) begin
            wr_ptr <= wr_ptr + ADDR_NBIT'(1);
         end else if (state_q != ST_FILL || do_restart) begin
            wr_ptr <= '0;
         end

         if (do_swap) begin
            rd_ptr <= '0;
         end else if (ad_rd) begin
            rd_ptr <= rd_ptr + ADDR_NBIT'(1);
         end

         rd_cnt <= do_swap ? '0 : rd_cnt_nxt;

         if (do_start) begin
            ad_ovf <= 1'b0;
         end else if (do_swap && rd_valid && !rd_cnt_nxt[ADDR_NBIT]) begin
            ad_ovf <= 1'b1;
         end

         if (do_start) begin
            rd_valid  <= 1'b0;
            frame_cnt <= '0;
         end else if (do_swap) begin
            rd_valid  <= 1'b1;
            frame_cnt <= frame_cnt + CNT_NBIT'(1);
         end

         if (do_swap) begin
            rd_bank   <= wr_bank;
            wr_bank   <= ~wr_bank;
            ad_cnt    <= frame_cnt;
            ad_switch <= ~ad_switch;
         end
      end
   end

   // bank RAM: one write port, one synchronous read port
   always_ff @(posedge mclk) begin
      if (do_write) begin
         mem[{wr_bank, wr_ptr}] <= wr_word;
      end
      ram_q <= mem[{rd_bank, rd_ptr}];
   end

   always_ff @(posedge mclk or negedge rst_n) begin
      if (!rst_n) begin
         ad_data <= '0;
      end else begin
         ad_data <= ram_q;
      end
   end

endmodule

// File: doc/adc_pingpong_buf.md
Name: adc_pingpong_buf

Overview:
Upstream feeder for the command/TX stage. Captures ADC samples of the selected channel into a two-bank (ping/pong) on-chip buffer. Each time a bank fills, it toggles ad_switch and exposes the full bank through a read port with read-advance (ad_rd/ad_data). It also exposes a running frame counter (ad_cnt), which the TX stage streams to USB after the message header.

Parameters:
DATA_NBIT, 16, sample and read word width (matches USB word width)
ADDR_NBIT, 10, words per bank = 2**ADDR_NBIT
CNT_NBIT, 32, frame counter width
CHN_NBIT, 3, ADC channel select width

Ports:
mclk  in  1  main clock 48 MHz
rst_n  in  1  asynchronous active-low reset
ad_acq_en  in  1  acquisition enable from command stage
ad_chn  in  CHN_NBIT  requested channel from command stage
adc_vd  in  1  ADC sample strobe, one mclk cycle per sample
adc_data  in  DATA_NBIT  ADC sample, valid with adc_vd
adc_chn_sel  out  CHN_NBIT  registered channel select to analog mux
ad_switch  out  1  toggles once per completed bank
ad_rd  in  1  read-advance from TX stage
ad_data  out  DATA_NBIT  current word of the readable bank
ad_cnt  out  CNT_NBIT  index of the frame in the readable bank
ad_ovf  out  1  sticky overrun flag

Behaviour:
- Reset (rst_n low, async): adc_chn_sel=0, ad_switch=0, ad_data=0, ad_cnt=0, ad_ovf=0. Internal state: wr_bank=0, wr_ptr=0, rd_ptr=0, frame counter=0, FSM=IDLE.
- Storage: 2*2**ADDR_NBIT x DATA_NBIT RAM. Address = {bank, ptr}. Single write port, single synchronous read port.
- FSM states:
  - IDLE: wr_ptr held at 0. Go to FILL on the rising edge of ad_acq_en. On entry, clear the frame counter and ad_ovf, and latch adc_chn_sel<=ad_chn.
  - FILL: each adc_vd writes adc_data to {wr_bank, wr_ptr}, then wr_ptr+1.
    - When a write lands at wr_ptr=all-ones, go to SWAP.
    - ad_acq_en low: go to IDLE, discard the partial bank, leave ad_switch untouched.
    - ad_chn differs from adc_chn_sel: latch the new channel, reset wr_ptr=0, discard partial data, stay in FILL.
  - SWAP (one cycle):
    - readable bank <= wr_bank; wr_bank <= ~wr_bank; wr_ptr <= 0; rd_ptr <= 0.
    - ad_cnt <= frame counter; frame counter +1 (wraps modulo 2**CNT_NBIT).
    - Toggle ad_switch. Return to FILL, or to IDLE if ad_acq_en is low.
    - adc_vd arriving in SWAP is dropped; the ADC sample rate guarantees at least 2 mclk between strobes.
- Read port:
  - ad_data always shows the word at {rd_bank, rd_ptr}. It is registered and valid 2 cycles after rd_ptr changes (RAM read plus output register).
  - ad_rd high for one cycle: rd_ptr+1. The next word appears on ad_data 2 cycles later.
  - The consumer may assert ad_rd back-to-back. rd_ptr wraps from all-ones to 0 with no error.
  - ad_rd in IDLE still advances rd_ptr over the last readable bank.
- Overrun: if SWAP occurs while the previous readable bank has fewer than 2**ADDR_NBIT ad_rd pulses since its own SWAP, set ad_ovf=1 (sticky until the next IDLE->FILL). Data is overwritten; no stall.
- Simultaneous events:
  - ad_rd during SWAP applies to the old rd_ptr, then rd_ptr is forced to 0 (swap wins).
  - ad_acq_en falling in the same cycle as the last write: the bank completes, SWAP runs, then the FSM goes to IDLE.
- ad_switch edges are the only bank-ready indication. The consumer detects any edge, in either direction.

Optional Feature:
ADC_TEST_PATTERN_EN
- Defined: adc_data is ignored. The written word is {adc_chn_sel zero-extended into the upper byte, wr_ptr[7:0]}, giving a deterministic ramp per channel for host-side link checking. Timing is identical and still driven by adc_vd.
- Undefined: adc_data is written unmodified.

Test Plan:
1. Reset mid-FILL with wr_ptr=300 -> all outputs return to reset values immediately (async); the next enable starts at wr_ptr=0.
2. ADDR_NBIT=4, acq_en=1, ad_chn=5, 16 strobes of data 0x1000..0x100F -> ad_switch toggles 0->1 and ad_cnt=0. Pulsing ad_rd 15 times reads 0x1000..0x100F on ad_data, each 2 cycles after its pulse.
3. Continue 32 more strobes -> ad_switch toggles twice and ad_cnt=2 with the rd bank alternating. With reads skipped for the second bank, ad_ovf=1 after the third swap.
4. Change ad_chn 5->2 after 7 strobes -> adc_chn_sel=2 next cycle. The bank completes only after 16 further strobes, and its first word is the sample taken after the change.
5. Drop acq_en after 9 strobes -> FSM returns to IDLE and ad_switch does not toggle. Re-enabling clears ad_cnt frame numbering to 0 and clears ad_ovf.
6. With ADC_TEST_PATTERN_EN, chn=3, ADDR_NBIT=4 -> the bank reads 0x0300..0x030F regardless of adc_data.
